// File: rtl/alu.sv
// Single-cycle registered ALU: combinational operation select, one register stage
// for result, zero flag and ready.
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            alu_ready
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] op_result;
  logic            slt_bit;
  logic            sltu_bit;

  assign shamt    = b[SHW-1:0];
  assign slt_bit  = $signed(a) < $signed(b);
  assign sltu_bit = a < b;

  // Codes outside the enum (1010-1111) fall through to default and yield zero.
  always_comb begin
    op_result = '0;
    case (alu_ctrl)
      OP_ADD:  op_result = a + b;
      OP_SUB:  op_result = a - b;
      OP_AND:  op_result = a & b;
      OP_OR:   op_result = a | b;
      OP_XOR:  op_result = a ^ b;
      OP_SLL:  op_result = a << shamt;
      OP_SRL:  op_result = a >> shamt;
      OP_SRA:  op_result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  op_result = {{(XLEN-1){1'b0}}, slt_bit};
      OP_SLTU: op_result = {{(XLEN-1){1'b0}}, sltu_bit};
      default: op_result = '0;
    endcase
  end

  // zero is taken from the same value being registered, never from the old result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      alu_ready <= 1'b0;
    end else begin
      result    <= op_result;
      zero      <= (op_result == '0);
      alu_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table, hand-written reset/pipeline sequences,
// and randomized traffic against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        alu_ready;

  int checks = 0;
  int errors = 0;

  alu #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .alu_ready(alu_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  ctrl;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_op(logic [31:0] x, logic [31:0] y, logic [3:0] op);
    logic [31:0] r;
    int unsigned s;
    s = y % 32;
    case (op)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << s;
      4'd6: r = x >> s;
      4'd7: begin
        r = x >> s;
        if (x[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      // signed compare via sign-bit flip onto an unsigned scale
      4'd8: r = ({~x[31], x[30:0]} < {~y[31], y[30:0]}) ? 32'd1 : 32'd0;
      4'd9: r = (x < y) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] op);
    rst = r; a = x; b = y; alu_ctrl = op;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] er, input logic ez,
                            input logic erdy);
    chk({name, ".result"}, result, er);
    chk({name, ".zero"}, {31'd0, zero}, {31'd0, ez});
    chk({name, ".ready"}, {31'd0, alu_ready}, {31'd0, erdy});
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb, er;
    logic [3:0]  rc;
    logic        rr;
    logic [31:0] hold_r;

    vecs = '{
      '{"add_neg",   32'hFFFF_FFFC, 32'hFFFF_FFFE, 4'b0000, 32'hFFFF_FFFA},
      '{"add_mix",   32'hFFFF_FFFC, 32'h0000_0003, 4'b0000, 32'hFFFF_FFFF},
      '{"add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 32'h0000_0000},
      '{"sub_pos",   32'd5,         32'd3,         4'b0001, 32'h0000_0002},
      '{"sub_neg",   32'hFFFF_FFFC, 32'hFFFF_FFFE, 4'b0001, 32'hFFFF_FFFE},
      '{"sub_mix",   32'hFFFF_FFFC, 32'h0000_0003, 4'b0001, 32'hFFFF_FFF9},
      '{"and",       32'hF,         32'hA,         4'b0010, 32'hA},
      '{"or",        32'hF,         32'hA,         4'b0011, 32'hF},
      '{"xor",       32'hF,         32'hA,         4'b0100, 32'h5},
      '{"sll",       32'hF,         32'h2,         4'b0101, 32'h3C},
      '{"srl",       32'hF,         32'h2,         4'b0110, 32'h3},
      '{"sra",       32'hF000_000F, 32'h2,         4'b0111, 32'hFC00_0003},
      '{"srl_hi",    32'hF000_000F, 32'h2,         4'b0110, 32'h3C00_0003},
      '{"sll_mask",  32'h1,         32'h21,        4'b0101, 32'h2},
      '{"sra_zero",  32'h8000_0001, 32'hFFFF_FFE0, 4'b0111, 32'h8000_0001},
      '{"sll_31",    32'h3,         32'h1F,        4'b0101, 32'h8000_0000},
      '{"slt",       32'hFFFF_FFFF, 32'h1,         4'b1000, 32'h1},
      '{"sltu",      32'hFFFF_FFFF, 32'h1,         4'b1001, 32'h0},
      '{"slt_eq",    32'h7,         32'h7,         4'b1000, 32'h0},
      '{"add_zero",  32'h0,         32'h0,         4'b0000, 32'h0},
      '{"inv_f",     32'd5,         32'd5,         4'b1111, 32'h0},
      '{"inv_a",     32'hFFFF_FFFF, 32'h1,         4'b1010, 32'h0}
    };

    // reset held two clocks, then first computed result
    drive(1'b1, 32'd7, 32'd9, 4'b0000);
    drive(1'b1, 32'd7, 32'd9, 4'b0000);
    expect_out("reset", 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'd5, 32'd3, 4'b0000);
    expect_out("first_add", 32'd8, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].va, vecs[i].vb, vecs[i].ctrl);
      expect_out(vecs[i].name, vecs[i].exp, vecs[i].exp == 32'h0, 1'b1);
    end

    // back-to-back ops, each visible exactly one edge later
    drive(1'b0, 32'd10, 32'd20, 4'b0000);
    expect_out("pipe_add", 32'd30, 1'b0, 1'b1);
    drive(1'b0, 32'd10, 32'd20, 4'b0001);
    expect_out("pipe_sub", 32'hFFFF_FFF6, 1'b0, 1'b1);
    drive(1'b0, 32'h1234_5678, 32'h1234_5678, 4'b0100);
    expect_out("pipe_xor", 32'h0, 1'b1, 1'b1);

    // outputs hold between edges while inputs move
    drive(1'b0, 32'd1, 32'd2, 4'b0000);
    hold_r = result;
    a = 32'hDEAD_BEEF; b = 32'h1; alu_ctrl = 4'b0011;
    #3;
    chk("hold_result", result, 32'd3);
    chk("hold_same", result, hold_r);

    // reset mid-stream discards the in-flight op
    drive(1'b1, 32'd4, 32'd4, 4'b0000);
    expect_out("mid_reset", 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'd4, 32'd4, 4'b0000);
    expect_out("post_reset", 32'd8, 1'b0, 1'b1);

    for (int unsigned n = 0; n < 400; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      rc = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 19) == 0);
      drive(rr, ra, rb, rc);
      if (rr) begin
        expect_out("rand_rst", 32'h0, 1'b1, 1'b0);
      end else begin
        er = ref_op(ra, rb, rc);
        expect_out($sformatf("rand_op%0d", rc), er, er == 32'h0, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
